// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared widths, types and one-hot helper for the 4-to-16 decoder
package decoder_pkg;

    localparam int DEC_ADDR_W = 4;
    localparam int DEC_OUT_N  = 16;

    typedef logic [DEC_ADDR_W-1:0] dec_sel_t;
    // Ascending range: element 0 is the leftmost/MSB position of the bus.
    typedef logic [0:DEC_OUT_N-1]  dec_out_t;

    localparam dec_out_t DEC_OUT_RST = '0;

    function automatic dec_out_t dec_onehot(input logic en, input dec_sel_t sel);
        dec_out_t res;
        res = '0;
        if (en) begin
            res[sel] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/dec_comb_4to16.sv
// rtl/dec_comb_4to16.sv - purely combinational enable-gated 4-to-16 one-hot decode
module dec_comb_4to16
    import decoder_pkg::*;
(
    input  logic        en,
    input  logic [3:0]  sel,
    output logic [0:15] dec_out
);

    always_comb begin
        dec_out = dec_onehot(en, sel);
    end

endmodule

// File: rtl/decoder_4to16_ah.sv
// rtl/decoder_4to16_ah.sv - registered 4-to-16 decoder, one-hot active-high D[0:15]
// Optional input register (latency 2) when DECODER_4TO16_IN_REG_EN is defined.
module decoder_4to16_ah
    import decoder_pkg::*;
#(
    parameter int ADDR_W = DEC_ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        E,
    input  logic [3:0]  A,
    output logic [0:15] D
);

    localparam int OUT_N = 2 ** ADDR_W;

    // The select width is fixed; any override must stop elaboration.
    if (ADDR_W != DEC_ADDR_W || OUT_N != DEC_OUT_N) begin : g_bad_addr_w
        $error("decoder_4to16_ah: ADDR_W must be 4");
    end

    logic     dec_en;
    dec_sel_t dec_sel;
    dec_out_t dec_next;

`ifdef DECODER_4TO16_IN_REG_EN
    logic     en_q;
    dec_sel_t sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q  <= 1'b0;
            sel_q <= '0;
        end else begin
            en_q  <= E;
            sel_q <= A;
        end
    end

    assign dec_en  = en_q;
    assign dec_sel = sel_q;
`else
    assign dec_en  = E;
    assign dec_sel = A;
`endif

    dec_comb_4to16 u_dec (
        .en      (dec_en),
        .sel     (dec_sel),
        .dec_out (dec_next)
    );

    // Output flop is the only state on the D path, so D never glitches between codes.
    always_ff @(posedge clk) begin
        if (rst) begin
            D <= DEC_OUT_RST;
        end else begin
            D <= dec_next;
        end
    end

endmodule

// File: tb/tb_decoder_4to16_ah.sv
// tb/tb_decoder_4to16_ah.sv - vector table plus randomized model check for decoder_4to16_ah
module tb_decoder_4to16_ah;

`ifdef DECODER_4TO16_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        rst;
        logic        e;
        logic [3:0]  a;
        logic [0:15] exp_d;
    } vec_t;

    typedef struct {
        logic       rst;
        logic       e;
        logic [3:0] a;
    } stim_t;

    logic        clk;
    logic        rst;
    logic        E;
    logic [3:0]  A;
    logic [0:15] D;

    int checks;
    int failures;

    vec_t        tbl[$];
    stim_t       hist[$];
    logic [0:15] exp_hist[$];

    decoder_4to16_ah dut (
        .clk (clk),
        .rst (rst),
        .E   (E),
        .A   (A),
        .D   (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:15] onehot(input logic [3:0] code);
        logic [15:0] v;
        v = 16'h8000 >> code;
        return v;
    endfunction

    // Output at edge n reflects the inputs sampled LAT-1 edges earlier,
    // forced to zero if reset was seen on any edge in that window.
    function automatic logic [0:15] model(input int n);
        int src;
        src = n - LAT + 1;
        for (int k = src; k <= n; k++) begin
            if (k >= 0 && hist[k].rst) return 16'h0000;
        end
        if (src < 0) return 16'h0000;
        return hist[src].e ? onehot(hist[src].a) : 16'h0000;
    endfunction

    function automatic vec_t mk(input logic r, input logic e, input logic [3:0] a,
                                input logic [0:15] d);
        vec_t v;
        v.rst = r; v.e = e; v.a = a; v.exp_d = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [0:15] got, input logic [0:15] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: D=%h expected %h", name, got, want);
        end
    endtask

    task automatic apply(input logic r, input logic e, input logic [3:0] a);
        stim_t s;
        rst = r; E = e; A = a;
        s.rst = r; s.e = e; s.a = a;
        hist.push_back(s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:15] want;
        logic [3:0]  ra;
        checks   = 0;
        failures = 0;
        rst = 1'b1; E = 1'b0; A = 4'h0;

        // Reset with E=1/A=5 held, then release.
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 16'h0000));
        tbl.push_back(mk(1'b1, 1'b1, 4'h5, 16'h0000));
        tbl.push_back(mk(1'b0, 1'b1, 4'h5, 16'b0000_0100_0000_0000));
        // Full sweep with enable high.
        tbl.push_back(mk(1'b0, 1'b1, 4'h0, 16'h8000));
        for (int i = 1; i < 15; i++) tbl.push_back(mk(1'b0, 1'b1, 4'(i), onehot(4'(i))));
        tbl.push_back(mk(1'b0, 1'b1, 4'hF, 16'h0001));
        // Enable low masks every code.
        for (int i = 0; i < 16; i++) tbl.push_back(mk(1'b0, 1'b0, 4'(i), 16'h0000));
        tbl.push_back(mk(1'b0, 1'b1, 4'h3, 16'h1000));
        // Back-to-back 7 <-> 8.
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(mk(1'b0, 1'b1, 4'h7, 16'h0100));
            tbl.push_back(mk(1'b0, 1'b1, 4'h8, 16'h0080));
        end
        // Mid-stream reset pulse at A=A.
        tbl.push_back(mk(1'b0, 1'b1, 4'h9, 16'h0040));
        tbl.push_back(mk(1'b1, 1'b1, 4'hA, 16'h0000));
        tbl.push_back(mk(1'b0, 1'b1, 4'hA, 16'b0000_0000_0010_0000));
        tbl.push_back(mk(1'b0, 1'b1, 4'hB, 16'h0010));
        tbl.push_back(mk(1'b0, 1'b1, 4'hC, 16'h0008));

        exp_hist.push_back(16'h0000);
        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].e, tbl[i].a);
            exp_hist.push_back(tbl[i].exp_d);
            want = tbl[i].rst ? 16'h0000 : exp_hist[exp_hist.size() - LAT];
            check($sformatf("vec%0d", i), D, want);
            if (want != 16'h0000) begin
                checks++;
                if ($countones(D) != 1) begin
                    failures++;
                    $display("FAIL onehot%0d: ones=%0d expected 1", i, $countones(D));
                end
            end
        end

        // Randomized traffic against the behavioural model.
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(0, 15));
            apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), ra);
            check($sformatf("rand%0d", i), D, model(hist.size() - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
